// File: rtl/rob_multi_retire.sv
// rob_multi_retire: reorder buffer with in-order multi-retire, per-entry exception and flush
// Ports: i_clk/i_rst (sync, active-high)/i_flush; dispatch i_ins_count/i_ins_bundle/i_ins_old_p
// -> o_ins_accept/o_ins_idx; completion i_cmpl_en/i_cmpl_idx/i_cmpl_exc; registered retire
// o_ret_count/o_ret_bundle/o_ret_old_p/o_ret_exc; occupancy o_count/o_full/o_empty.
module rob_multi_retire #(
    parameter int DEPTH      = 16,
    parameter int DISPATCH_W = 4,
    parameter int CMPL_W     = 6,
    parameter int RETIRE_W   = 4,
    parameter int BUNDLE_W   = 57,
    parameter int PREG_W     = 6,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int DC_W  = $clog2(DISPATCH_W + 1),
    localparam int RC_W  = $clog2(RETIRE_W + 1)
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_flush,
    input  logic [DC_W-1:0]                i_ins_count,
    input  logic [DISPATCH_W*BUNDLE_W-1:0] i_ins_bundle,
    input  logic [DISPATCH_W*PREG_W-1:0]   i_ins_old_p,
    output logic                           o_ins_accept,
    output logic [DISPATCH_W*IDX_W-1:0]    o_ins_idx,
    input  logic [CMPL_W-1:0]              i_cmpl_en,
    input  logic [CMPL_W*IDX_W-1:0]        i_cmpl_idx,
    input  logic [CMPL_W-1:0]              i_cmpl_exc,
    output logic [RC_W-1:0]                o_ret_count,
    output logic [RETIRE_W*BUNDLE_W-1:0]   o_ret_bundle,
    output logic [RETIRE_W*PREG_W-1:0]     o_ret_old_p,
    output logic                           o_ret_exc,
    output logic [CNT_W-1:0]               o_count,
    output logic                           o_full,
    output logic                           o_empty
);
    logic [IDX_W-1:0]    head, tail;
    logic [DEPTH-1:0]    valid, done, exc;
    logic [DEPTH-1:0]    disp_mask, ret_mask, done_set, exc_set;
    logic [BUNDLE_W-1:0] bun_q [DEPTH];
    logic [PREG_W-1:0]   oldp_q [DEPTH];
    logic [RC_W-1:0]     ret_n;
    logic [DC_W-1:0]     acc_n;
    logic                ret_stop;

    assign o_ins_accept = !i_flush && 32'(i_ins_count) <= DISPATCH_W
                          && 32'(i_ins_count) <= DEPTH - 32'(o_count);
    assign acc_n   = o_ins_accept ? i_ins_count : '0;
    assign o_full  = o_count == CNT_W'(DEPTH);
    assign o_empty = o_count == '0;

    always_comb begin
        o_ins_idx = '0;
        disp_mask = '0;
        for (int k = 0; k < DISPATCH_W; k++) begin
            o_ins_idx[k*IDX_W +: IDX_W] = tail + IDX_W'(k);
            if (DC_W'(k) < acc_n) disp_mask[tail + IDX_W'(k)] = 1'b1;
        end
    end

    // Multiple ports hitting one tag must OR their exception flags, so merge here.
    always_comb begin
        done_set = '0;
        exc_set  = '0;
        for (int p = 0; p < CMPL_W; p++) begin
            if (i_cmpl_en[p] && valid[i_cmpl_idx[p*IDX_W +: IDX_W]]) begin
                done_set[i_cmpl_idx[p*IDX_W +: IDX_W]] = 1'b1;
                exc_set[i_cmpl_idx[p*IDX_W +: IDX_W]]  = exc_set[i_cmpl_idx[p*IDX_W +: IDX_W]] | i_cmpl_exc[p];
            end
        end
    end

    // Longest in-order run of finished entries; an excepting entry retires only alone in slot 0.
    always_comb begin
        ret_n    = '0;
        ret_mask = '0;
        ret_stop = 1'b0;
        for (int r = 0; r < RETIRE_W; r++) begin
            if (!ret_stop && valid[head + IDX_W'(r)] && done[head + IDX_W'(r)]
                && (r == 0 || !exc[head + IDX_W'(r)])) begin
                ret_n = RC_W'(r + 1);
                ret_mask[head + IDX_W'(r)] = 1'b1;
            end else begin
                ret_stop = 1'b1;
            end
            if (r == 0 && exc[head]) ret_stop = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < DISPATCH_W; k++) begin
            if (!i_rst && DC_W'(k) < acc_n) begin
                bun_q[tail + IDX_W'(k)]  <= i_ins_bundle[k*BUNDLE_W +: BUNDLE_W];
                oldp_q[tail + IDX_W'(k)] <= i_ins_old_p[k*PREG_W +: PREG_W];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head         <= '0;
            tail         <= '0;
            o_count      <= '0;
            valid        <= '0;
            done         <= '0;
            exc          <= '0;
            o_ret_count  <= '0;
            o_ret_bundle <= '0;
            o_ret_old_p  <= '0;
            o_ret_exc    <= 1'b0;
        end else if (i_flush) begin
            tail         <= head;
            o_count      <= '0;
            valid        <= '0;
            done         <= '0;
            exc          <= '0;
            o_ret_count  <= '0;
            o_ret_bundle <= '0;
            o_ret_old_p  <= '0;
            o_ret_exc    <= 1'b0;
        end else begin
            valid       <= (valid & ~ret_mask) | disp_mask;
            done        <= (done | done_set) & ~disp_mask;
            exc         <= (exc | exc_set) & ~disp_mask;
            head        <= head + IDX_W'(ret_n);
            tail        <= tail + IDX_W'(acc_n);
            o_count     <= o_count + CNT_W'(acc_n) - CNT_W'(ret_n);
            o_ret_count <= ret_n;
            o_ret_exc   <= ret_n != '0 && exc[head];
            for (int r = 0; r < RETIRE_W; r++) begin
                o_ret_bundle[r*BUNDLE_W +: BUNDLE_W] <= RC_W'(r) < ret_n ? bun_q[head + IDX_W'(r)] : '0;
                o_ret_old_p[r*PREG_W +: PREG_W]      <= RC_W'(r) < ret_n ? oldp_q[head + IDX_W'(r)] : '0;
            end
        end
    end
endmodule

// File: tb/tb_rob_multi_retire.sv
// tb_rob_multi_retire: directed scenarios for the reorder buffer with inline expected values
module tb_rob_multi_retire;
    logic           i_clk = 1'b0;
    logic           i_rst = 1'b1;
    logic           i_flush = 1'b0;
    logic [2:0]     i_ins_count = '0;
    logic [4*57-1:0] i_ins_bundle = '0;
    logic [4*6-1:0] i_ins_old_p = '0;
    logic           o_ins_accept;
    logic [15:0]    o_ins_idx;
    logic [5:0]     i_cmpl_en = '0;
    logic [23:0]    i_cmpl_idx = '0;
    logic [5:0]     i_cmpl_exc = '0;
    logic [2:0]     o_ret_count;
    logic [4*57-1:0] o_ret_bundle;
    logic [23:0]    o_ret_old_p;
    logic           o_ret_exc;
    logic [4:0]     o_count;
    logic           o_full;
    logic           o_empty;
    int             n_cmp = 0;
    int             n_err = 0;

    rob_multi_retire dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
        .i_ins_count(i_ins_count), .i_ins_bundle(i_ins_bundle), .i_ins_old_p(i_ins_old_p),
        .o_ins_accept(o_ins_accept), .o_ins_idx(o_ins_idx),
        .i_cmpl_en(i_cmpl_en), .i_cmpl_idx(i_cmpl_idx), .i_cmpl_exc(i_cmpl_exc),
        .o_ret_count(o_ret_count), .o_ret_bundle(o_ret_bundle), .o_ret_old_p(o_ret_old_p),
        .o_ret_exc(o_ret_exc), .o_count(o_count), .o_full(o_full), .o_empty(o_empty)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [56:0] bun(input int b);
        return 57'h1234_5000_0000 + 57'(b);
    endfunction

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic offer(input int n, input int base);
        i_ins_count = 3'(n);
        for (int k = 0; k < 4; k++) begin
            i_ins_bundle[k*57 +: 57] = bun(base + k);
            i_ins_old_p[k*6 +: 6]    = 6'(base + k);
        end
    endtask

    task automatic set_cmpl(input int p, input int tag, input bit e);
        i_cmpl_en[p]         = 1'b1;
        i_cmpl_idx[p*4 +: 4] = 4'(tag);
        i_cmpl_exc[p]        = e;
    endtask

    task automatic clr_cmpl;
        i_cmpl_en  = '0;
        i_cmpl_exc = '0;
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        tick;
        tick;
        i_rst = 1'b0;
        n_cmp++; if (o_count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", o_count); end
        n_cmp++; if (o_empty !== 1'b1 || o_full !== 1'b0) begin n_err++; $display("FAIL reset_flags: got empty=%0b full=%0b want 1/0", o_empty, o_full); end
        n_cmp++; if (o_ret_count !== 3'd0 || o_ret_exc !== 1'b0) begin n_err++; $display("FAIL reset_ret: got cnt=%0d exc=%0b want 0/0", o_ret_count, o_ret_exc); end
        n_cmp++; if (o_ret_old_p !== 24'd0 || o_ret_bundle !== '0) begin n_err++; $display("FAIL reset_ret_data: got oldp=%0h want 0", o_ret_old_p); end
        n_cmp++; if (o_ins_accept !== 1'b1 || o_ins_idx !== 16'h3210) begin n_err++; $display("FAIL reset_idx: got acc=%0b idx=%0h want 1/3210", o_ins_accept, o_ins_idx); end
    endtask

    task automatic test_fill;
        for (int c = 0; c < 4; c++) begin
            offer(4, 4 * c);
            #1;
            n_cmp++; if (o_ins_accept !== 1'b1) begin n_err++; $display("FAIL fill_accept%0d: got %0b want 1", c, o_ins_accept); end
            n_cmp++; if (o_ins_idx !== 16'(16'h3210 + 16'h4444 * c)) begin n_err++; $display("FAIL fill_idx%0d: got %0h want %0h", c, o_ins_idx, 16'(16'h3210 + 16'h4444 * c)); end
            tick;
        end
        offer(1, 99);
        #1;
        n_cmp++; if (o_count !== 5'd16 || o_full !== 1'b1) begin n_err++; $display("FAIL fill_full: got cnt=%0d full=%0b want 16/1", o_count, o_full); end
        n_cmp++; if (o_ins_accept !== 1'b0) begin n_err++; $display("FAIL fill_reject: got %0b want 0", o_ins_accept); end
        tick;
        offer(0, 0);
        n_cmp++; if (o_count !== 5'd16) begin n_err++; $display("FAIL fill_count_hold: got %0d want 16", o_count); end
    endtask

    task automatic test_retire_gap;
        set_cmpl(0, 0, 0); set_cmpl(1, 1, 0); set_cmpl(2, 2, 0); set_cmpl(3, 3, 0); set_cmpl(4, 5, 0);
        tick;
        clr_cmpl;
        n_cmp++; if (o_ret_count !== 3'd0) begin n_err++; $display("FAIL gap_latency: got %0d want 0", o_ret_count); end
        tick;
        n_cmp++; if (o_ret_count !== 3'd4) begin n_err++; $display("FAIL gap_count: got %0d want 4", o_ret_count); end
        n_cmp++; if (o_ret_old_p !== {6'd3, 6'd2, 6'd1, 6'd0}) begin n_err++; $display("FAIL gap_oldp: got %0h want %0h", o_ret_old_p, {6'd3, 6'd2, 6'd1, 6'd0}); end
        n_cmp++; if (o_ret_bundle[0 +: 57] !== bun(0)) begin n_err++; $display("FAIL gap_bundle: got %0h want %0h", o_ret_bundle[0 +: 57], bun(0)); end
        n_cmp++; if (o_count !== 5'd12) begin n_err++; $display("FAIL gap_occ: got %0d want 12", o_count); end
        tick;
        n_cmp++; if (o_ret_count !== 3'd0 || o_ret_old_p !== 24'd0) begin n_err++; $display("FAIL gap_block: got cnt=%0d oldp=%0h want 0/0", o_ret_count, o_ret_old_p); end
    endtask

    task automatic test_exception;
        set_cmpl(0, 4, 1); set_cmpl(1, 6, 0);
        tick;
        clr_cmpl;
        tick;
        n_cmp++; if (o_ret_count !== 3'd1 || o_ret_exc !== 1'b1) begin n_err++; $display("FAIL exc_alone: got cnt=%0d exc=%0b want 1/1", o_ret_count, o_ret_exc); end
        n_cmp++; if (o_ret_old_p !== 24'd4) begin n_err++; $display("FAIL exc_oldp: got %0h want 4", o_ret_old_p); end
        tick;
        n_cmp++; if (o_ret_count !== 3'd2 || o_ret_exc !== 1'b0) begin n_err++; $display("FAIL exc_after: got cnt=%0d exc=%0b want 2/0", o_ret_count, o_ret_exc); end
        n_cmp++; if (o_ret_old_p !== {12'd0, 6'd6, 6'd5} || o_count !== 5'd9) begin n_err++; $display("FAIL exc_after_data: got oldp=%0h cnt=%0d want 185/9", o_ret_old_p, o_count); end
        set_cmpl(0, 7, 0); set_cmpl(1, 7, 1); set_cmpl(2, 8, 0);
        tick;
        clr_cmpl;
        tick;
        n_cmp++; if (o_ret_count !== 3'd1 || o_ret_exc !== 1'b1 || o_ret_old_p !== 24'd7) begin n_err++; $display("FAIL exc_or: got cnt=%0d exc=%0b oldp=%0h want 1/1/7", o_ret_count, o_ret_exc, o_ret_old_p); end
        tick;
        n_cmp++; if (o_ret_count !== 3'd1 || o_ret_exc !== 1'b0 || o_ret_old_p !== 24'd8) begin n_err++; $display("FAIL exc_next: got cnt=%0d exc=%0b oldp=%0h want 1/0/8", o_ret_count, o_ret_exc, o_ret_old_p); end
        set_cmpl(0, 9, 0); set_cmpl(1, 10, 1);
        tick;
        clr_cmpl;
        tick;
        n_cmp++; if (o_ret_count !== 3'd1 || o_ret_exc !== 1'b0 || o_ret_old_p !== 24'd9) begin n_err++; $display("FAIL exc_ends_run: got cnt=%0d exc=%0b oldp=%0h want 1/0/9", o_ret_count, o_ret_exc, o_ret_old_p); end
        tick;
        n_cmp++; if (o_ret_count !== 3'd1 || o_ret_exc !== 1'b1 || o_ret_old_p !== 24'd10) begin n_err++; $display("FAIL exc_later: got cnt=%0d exc=%0b oldp=%0h want 1/1/a", o_ret_count, o_ret_exc, o_ret_old_p); end
        n_cmp++; if (o_count !== 5'd5) begin n_err++; $display("FAIL exc_occ: got %0d want 5", o_count); end
    endtask

    task automatic test_wrap;
        offer(2, 16);
        set_cmpl(0, 11, 0); set_cmpl(1, 12, 0); set_cmpl(2, 13, 0);
        #1;
        n_cmp++; if (o_ins_accept !== 1'b1 || o_ins_idx[7:0] !== 8'h10) begin n_err++; $display("FAIL wrap_idx: got acc=%0b idx=%0h want 1/10", o_ins_accept, o_ins_idx[7:0]); end
        tick;
        offer(0, 0);
        clr_cmpl;
        n_cmp++; if (o_count !== 5'd7) begin n_err++; $display("FAIL wrap_occ7: got %0d want 7", o_count); end
        tick;
        n_cmp++; if (o_ret_count !== 3'd3 || o_count !== 5'd4) begin n_err++; $display("FAIL wrap_pre: got ret=%0d cnt=%0d want 3/4", o_ret_count, o_count); end
        set_cmpl(0, 14, 0); set_cmpl(1, 15, 0); set_cmpl(2, 0, 0); set_cmpl(3, 1, 0);
        tick;
        clr_cmpl;
        tick;
        n_cmp++; if (o_ret_count !== 3'd4) begin n_err++; $display("FAIL wrap_count: got %0d want 4", o_ret_count); end
        n_cmp++; if (o_ret_old_p !== {6'd17, 6'd16, 6'd15, 6'd14}) begin n_err++; $display("FAIL wrap_oldp: got %0h want %0h", o_ret_old_p, {6'd17, 6'd16, 6'd15, 6'd14}); end
        n_cmp++; if (o_ret_bundle[3*57 +: 57] !== bun(17)) begin n_err++; $display("FAIL wrap_bundle: got %0h want %0h", o_ret_bundle[3*57 +: 57], bun(17)); end
        n_cmp++; if (o_count !== 5'd0 || o_empty !== 1'b1) begin n_err++; $display("FAIL wrap_empty: got cnt=%0d empty=%0b want 0/1", o_count, o_empty); end
    endtask

    task automatic test_back_to_back;
        for (int c = 0; c < 4; c++) begin
            offer(4, 32 + 4 * c);
            tick;
        end
        offer(0, 0);
        n_cmp++; if (o_full !== 1'b1) begin n_err++; $display("FAIL b2b_full: got %0b want 1", o_full); end
        set_cmpl(0, 2, 0); set_cmpl(1, 3, 0); set_cmpl(2, 4, 0); set_cmpl(3, 5, 0);
        tick;
        clr_cmpl;
        offer(4, 48);
        #1;
        n_cmp++; if (o_ins_accept !== 1'b0) begin n_err++; $display("FAIL b2b_reject: got %0b want 0", o_ins_accept); end
        tick;
        n_cmp++; if (o_ret_count !== 3'd4 || o_count !== 5'd12) begin n_err++; $display("FAIL b2b_retire: got ret=%0d cnt=%0d want 4/12", o_ret_count, o_count); end
        n_cmp++; if (o_ret_old_p !== {6'd35, 6'd34, 6'd33, 6'd32}) begin n_err++; $display("FAIL b2b_oldp: got %0h want %0h", o_ret_old_p, {6'd35, 6'd34, 6'd33, 6'd32}); end
        n_cmp++; if (o_ins_accept !== 1'b1 || o_ins_idx !== 16'h5432) begin n_err++; $display("FAIL b2b_accept: got acc=%0b idx=%0h want 1/5432", o_ins_accept, o_ins_idx); end
        tick;
        offer(0, 0);
        n_cmp++; if (o_count !== 5'd16 || o_ret_count !== 3'd0) begin n_err++; $display("FAIL b2b_refill: got cnt=%0d ret=%0d want 16/0", o_count, o_ret_count); end
    endtask

    task automatic test_flush;
        set_cmpl(0, 6, 0); set_cmpl(1, 7, 0);
        tick;
        clr_cmpl;
        tick;
        n_cmp++; if (o_ret_count !== 3'd2 || o_count !== 5'd14) begin n_err++; $display("FAIL flush_pre: got ret=%0d cnt=%0d want 2/14", o_ret_count, o_count); end
        i_flush = 1'b1;
        offer(2, 60);
        set_cmpl(0, 8, 0);
        #1;
        n_cmp++; if (o_ins_accept !== 1'b0) begin n_err++; $display("FAIL flush_accept: got %0b want 0", o_ins_accept); end
        tick;
        i_flush = 1'b0;
        offer(0, 0);
        clr_cmpl;
        n_cmp++; if (o_count !== 5'd0 || o_empty !== 1'b1) begin n_err++; $display("FAIL flush_empty: got cnt=%0d empty=%0b want 0/1", o_count, o_empty); end
        n_cmp++; if (o_ret_count !== 3'd0 || o_ret_exc !== 1'b0) begin n_err++; $display("FAIL flush_ret: got cnt=%0d exc=%0b want 0/0", o_ret_count, o_ret_exc); end
        tick;
        offer(1, 61);
        #1;
        n_cmp++; if (o_ins_accept !== 1'b1 || o_ins_idx[3:0] !== 4'd8) begin n_err++; $display("FAIL flush_tail: got acc=%0b idx=%0h want 1/8", o_ins_accept, o_ins_idx[3:0]); end
        tick;
        offer(0, 0);
        tick;
        n_cmp++; if (o_count !== 5'd1 || o_ret_count !== 3'd0) begin n_err++; $display("FAIL flush_drop_cmpl: got cnt=%0d ret=%0d want 1/0", o_count, o_ret_count); end
    endtask

    task automatic test_reset_mid;
        set_cmpl(0, 8, 1);
        tick;
        clr_cmpl;
        tick;
        n_cmp++; if (o_ret_count !== 3'd1 || o_ret_exc !== 1'b1 || o_ret_old_p !== 24'd61) begin n_err++; $display("FAIL mid_pre: got cnt=%0d exc=%0b oldp=%0h want 1/1/3d", o_ret_count, o_ret_exc, o_ret_old_p); end
        offer(2, 0);
        set_cmpl(0, 9, 0);
        i_rst = 1'b1;
        tick;
        i_rst = 1'b0;
        offer(0, 0);
        clr_cmpl;
        n_cmp++; if (o_count !== 5'd0 || o_empty !== 1'b1) begin n_err++; $display("FAIL mid_occ: got cnt=%0d empty=%0b want 0/1", o_count, o_empty); end
        n_cmp++; if (o_ret_count !== 3'd0 || o_ret_exc !== 1'b0 || o_ret_old_p !== 24'd0 || o_ret_bundle !== '0) begin n_err++; $display("FAIL mid_ret: got cnt=%0d exc=%0b oldp=%0h want 0/0/0", o_ret_count, o_ret_exc, o_ret_old_p); end
        n_cmp++; if (o_ins_idx !== 16'h3210) begin n_err++; $display("FAIL mid_tail: got %0h want 3210", o_ins_idx); end
    endtask

    initial begin
        test_reset;
        test_fill;
        test_retire_gap;
        test_exception;
        test_wrap;
        test_back_to_back;
        test_flush;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
